// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration loader.
// Holds the truth-table width, FSM state encoding and the one-hot enable helper.
package lut_cfg_pkg;

    localparam int LUT_BITS = 8;
    localparam int MAX_LUTS = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Callers truncate the result to their own LUT count.
    function automatic logic [MAX_LUTS-1:0] onehot(input logic [7:0] addr);
        logic [MAX_LUTS-1:0] v;
        v = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-load, MSB-first shift register feeding the serial config line.
// Zeros are shifted in, so the register drains to 0 after a full load.
module cfg_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q_msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign q_msb = sr[W-1];

endmodule

// File: rtl/lut_cfg_loader.sv
// Serialises 8-bit truth-table words into one of NUM_LUTS LUT cells,
// driving the shared cfg_s line and that LUT's shift enable for 8 cycles.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [LUT_BITS-1:0] in_data,
    output logic                cfg_s,
    output logic [NUM_LUTS-1:0] cfg_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output state_t              state
);

    localparam int CNT_W = $clog2(LUT_BITS);
    localparam logic [ADDR_W:0] NUM_LUTS_W = (ADDR_W + 1)'(NUM_LUTS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LUT_BITS - 1);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready
    // are both high; in_valid while in_ready is low is ignored and the upstream
    // must keep holding its word.
    logic                accept;
    logic                addr_ok;
    logic [NUM_LUTS-1:0] en_next;
    logic [CNT_W-1:0]    cnt;

    assign accept  = in_valid && in_ready && (state == IDLE);
    assign addr_ok = {1'b0, in_addr} < NUM_LUTS_W;
    assign en_next = NUM_LUTS'(onehot(8'(in_addr)));

    // cfg_s is taken straight from the shift register flop, so it is registered.
    cfg_piso #(.W(LUT_BITS)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && addr_ok),
        .shift (state == SHIFT),
        .d     (in_data),
        .q_msb (cfg_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            cfg_en   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (addr_ok) begin
                            state    <= SHIFT;
                            cfg_en   <= en_next;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state  <= DONE;
                        cfg_en <= '0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    cfg_en   <= '0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader with a behavioural LUT array model
// that shifts cfg_s into Q on each rising edge its enable is high.
module tb_lut_cfg_loader;
    import lut_cfg_pkg::*;

    logic       clk;
    logic       rst;
    int         n_checks;
    int         n_fail;

    // Main instance: 8 LUTs.
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_addr;
    logic [7:0] in_data;
    logic       cfg_s;
    logic [7:0] cfg_en;
    logic       busy;
    logic       done;
    logic       err;
    state_t     st;

    // Second instance: 6 LUTs, for out-of-range addresses.
    logic       v6;
    logic       ready6;
    logic [2:0] a6;
    logic [7:0] d6;
    logic       cfg_s6;
    logic [5:0] en6;
    logic       busy6;
    logic       done6;
    logic       err6;
    state_t     st6;

    logic [7:0] lut_q [8];

    lut_cfg_loader #(.NUM_LUTS(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .cfg_s(cfg_s), .cfg_en(cfg_en),
        .busy(busy), .done(done), .err(err), .state(st)
    );

    lut_cfg_loader #(.NUM_LUTS(6), .ADDR_W(3)) dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(ready6),
        .in_addr(a6), .in_data(d6), .cfg_s(cfg_s6), .cfg_en(en6),
        .busy(busy6), .done(done6), .err(err6), .state(st6)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (cfg_en[i]) lut_q[i] <= {lut_q[i][6:0], cfg_s};
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver + stream checks for one load ----------------
    // Starts at a negedge with dut idle; ends at the negedge where it is idle again.
    // glitch_k >= 0 pulses a different word on in_valid during SHIFT cycle glitch_k.
    task automatic run_load(input logic [2:0] a, input logic [7:0] d, input int glitch_k, input string tag);
        logic [7:0] oh;
        oh = 8'd1 << a;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_pre: got %b expected 1", tag, in_ready); end
        in_valid = 1'b1; in_addr = a; in_data = d;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == glitch_k) begin
                in_valid = 1'b1; in_addr = ~a; in_data = ~d;
            end else if (glitch_k >= 0 && k == glitch_k + 1) begin
                in_valid = 1'b0;
            end
            n_checks++; if (cfg_en !== oh) begin n_fail++; $display("FAIL %s en k=%0d: got %b expected %b", tag, k, cfg_en, oh); end
            n_checks++; if (cfg_s !== d[7-k]) begin n_fail++; $display("FAIL %s cfg_s k=%0d: got %b expected %b", tag, k, cfg_s, d[7-k]); end
            n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL %s ctl k=%0d: got busy=%b ready=%b done=%b expected 1 0 0", tag, k, busy, in_ready, done);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || cfg_en !== 8'd0 || cfg_s !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s done_cycle: got done=%b en=%b s=%b busy=%b ready=%b expected 1 0 0 1 0", tag, done, cfg_en, cfg_s, busy, in_ready);
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || st !== IDLE) begin
            n_fail++; $display("FAIL %s idle_after: got done=%b busy=%b ready=%b state=%0d expected 0 0 1 0", tag, done, busy, in_ready, st);
        end
        n_checks++; if (lut_q[a] !== d) begin n_fail++; $display("FAIL %s lut_q: got %h expected %h", tag, lut_q[a], d); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        v6 = 1'b0; a6 = '0; d6 = '0;
        for (int i = 0; i < 8; i++) lut_q[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || cfg_s !== 1'b0 || cfg_en !== 8'd0) begin
            n_fail++; $display("FAIL reset_data: got ready=%b s=%b en=%b expected 1 0 0", in_ready, cfg_s, cfg_en);
        end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || st !== IDLE) begin
            n_fail++; $display("FAIL reset_ctl: got busy=%b done=%b err=%b state=%0d expected 0 0 0 0", busy, done, err, st);
        end
        n_checks++; if (ready6 !== 1'b1 || en6 !== 6'd0 || err6 !== 1'b0 || busy6 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut6: got ready=%b en=%b err=%b busy=%b expected 1 0 0 0", ready6, en6, err6, busy6);
        end
    endtask

    task automatic test_majority();
        logic a, b, c, z, exp_z;
        run_load(3'd2, 8'hE8, -1, "majority");
        for (int abc = 0; abc < 8; abc++) begin
            a = abc[2]; b = abc[1]; c = abc[0];
            exp_z = (a & b) | (a & c) | (b & c);
            z = lut_q[2][abc];
            n_checks++; if (z !== exp_z) begin n_fail++; $display("FAIL majority_z abc=%0d: got %b expected %b", abc, z, exp_z); end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2;
        acc1 = -1; acc2 = -1;
        in_valid = 1'b1; in_addr = 3'd0; in_data = 8'h96;
        for (int t = 0; t < 30; t++) begin
            if (in_valid && in_ready) begin
                if (acc1 < 0) acc1 = t;
                else if (acc2 < 0) acc2 = t;
            end
            n_checks++; if ($countones(cfg_en) > 1) begin n_fail++; $display("FAIL b2b_onehot t=%0d: got %b expected at most one bit", t, cfg_en); end
            @(negedge clk);
            if (acc1 >= 0 && acc2 < 0 && t == acc1) begin in_addr = 3'd7; in_data = 8'h01; end
            if (acc2 >= 0) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++; if (acc1 !== 0) begin n_fail++; $display("FAIL b2b_first_accept: got %0d expected 0", acc1); end
        n_checks++; if (acc2 - acc1 !== 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 10", acc2 - acc1); end
        n_checks++; if (lut_q[0] !== 8'h96) begin n_fail++; $display("FAIL b2b_lut0: got %h expected 96", lut_q[0]); end
        n_checks++; if (lut_q[7] !== 8'h01) begin n_fail++; $display("FAIL b2b_lut7: got %h expected 01", lut_q[7]); end
    endtask

    task automatic test_bad_addr();
        logic [2:0] bad [2];
        bad[0] = 3'd7; bad[1] = 3'd6;
        for (int i = 0; i < 2; i++) begin
            v6 = 1'b1; a6 = bad[i]; d6 = 8'hAA;
            @(negedge clk);
            v6 = 1'b0;
            n_checks++; if (err6 !== 1'b1 || en6 !== 6'd0 || ready6 !== 1'b1 || done6 !== 1'b0 || busy6 !== 1'b0) begin
                n_fail++; $display("FAIL bad_addr_%0d: got err=%b en=%b ready=%b done=%b busy=%b expected 1 0 1 0 0", bad[i], err6, en6, ready6, done6, busy6);
            end
            @(negedge clk);
            n_checks++; if (err6 !== 1'b0 || en6 !== 6'd0 || st6 !== IDLE) begin
                n_fail++; $display("FAIL bad_addr_after_%0d: got err=%b en=%b state=%0d expected 0 0 0", bad[i], err6, en6, st6);
            end
        end
        v6 = 1'b1; a6 = 3'd5; d6 = 8'hA5;
        @(negedge clk);
        v6 = 1'b0;
        n_checks++; if (en6 !== 6'b100000 || err6 !== 1'b0 || cfg_s6 !== 1'b1) begin
            n_fail++; $display("FAIL top_addr_load: got en=%b err=%b s=%b expected 100000 0 1", en6, err6, cfg_s6);
        end
        repeat (8) @(negedge clk);
        n_checks++; if (done6 !== 1'b1 || en6 !== 6'd0) begin n_fail++; $display("FAIL top_addr_done: got done=%b en=%b expected 1 0", done6, en6); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        in_valid = 1'b1; in_addr = 3'd3; in_data = 8'h5A;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (cfg_en !== 8'b0000_1000 || cfg_s !== 1'b1) begin
            n_fail++; $display("FAIL abort_k4: got en=%b s=%b expected 00001000 1", cfg_en, cfg_s);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (cfg_en !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || st !== IDLE || cfg_s !== 1'b0) begin
            n_fail++; $display("FAIL abort_after: got en=%b busy=%b ready=%b done=%b state=%0d s=%b expected 0 0 1 0 0 0", cfg_en, busy, in_ready, done, st, cfg_s);
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cfg_en !== 8'd0) begin n_fail++; $display("FAIL abort_no_done: got done=%b en=%b expected 0 0", done, cfg_en); end
        run_load(3'd3, 8'hFF, -1, "reload_ff");
        // A word offered in the same cycle as reset must not be taken.
        rst = 1'b1; in_valid = 1'b1; in_addr = 3'd1; in_data = 8'h33;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || cfg_en !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_with_valid: got busy=%b en=%b ready=%b expected 0 0 1", busy, cfg_en, in_ready);
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [7:0] lut1_before;
        lut1_before = lut_q[1];
        run_load(3'd4, 8'hC3, 2, "ignore_busy");
        n_checks++; if (lut_q[1] !== lut1_before) begin n_fail++; $display("FAIL ignore_busy_lut1: got %h expected %h", lut_q[1], lut1_before); end
        n_checks++; if (busy !== 1'b0 || cfg_en !== 8'd0) begin n_fail++; $display("FAIL ignore_busy_no_load: got busy=%b en=%b expected 0 0", busy, cfg_en); end
    endtask

    task automatic test_exhaustive();
        logic [7:0] d;
        for (int v = 0; v < 256; v++) begin
            d = 8'(v);
            run_load(3'd0, d, -1, "exhaustive");
            for (int abc = 0; abc < 8; abc++) begin
                n_checks++; if (lut_q[0][abc] !== d[abc]) begin
                    n_fail++; $display("FAIL exhaustive_z data=%h abc=%0d: got %b expected %b", d, abc, lut_q[0][abc], d[abc]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_majority();
        test_back_to_back();
        test_bad_addr();
        test_reset_mid_shift();
        test_ignore_while_busy();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
Configuration writer for the 3-input LUT cells. It accepts parallel 8-bit truth-table words addressed to one of NUM_LUTS LUTs over a valid/ready handshake. It serialises each word onto a shared serial data line (cfg_s) and pulses that LUT's shift-enable for exactly 8 cycles. After the load, target LUT bit Q[i] equals word bit i. The block sits between the configuration controller and the LUT array, one loader per array.

Parameters:
NUM_LUTS, 8, number of LUT cells driven; each owns one cfg_en bit.
ADDR_W, 3, width of cfg_addr; must satisfy 2**ADDR_W >= NUM_LUTS.
LUT_BITS, 8, truth-table width (bits shifted per load); fixed at 8 for 3-input LUTs.

Ports:
clk  input  1  rising-edge clock, shared with the LUT array.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  a config word is offered.
in_ready  output  1  loader can accept a word this cycle.
in_addr  input  ADDR_W  index of the target LUT.
in_data  input  LUT_BITS  truth table; bit i is the output for {A,B,C}=i.
cfg_s  output  1  serial config data, shared by all LUTs.
cfg_en  output  NUM_LUTS  one-hot shift enable; at most one bit high.
busy  output  1  high while a load is in progress (SHIFT or DONE).
done  output  1  one-cycle pulse when a load completes.
err  output  1  one-cycle pulse when a word with in_addr >= NUM_LUTS is rejected.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=1, cfg_s=0, cfg_en=0, busy=0, done=0, err=0, state=IDLE, bit counter=0.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready with in_addr < NUM_LUTS, latch in_data into the shift register and in_addr, then go to SHIFT.
  - IDLE with in_addr >= NUM_LUTS: the word is consumed, err=1 for the next cycle, state stays IDLE, nothing is shifted.
  - SHIFT: lasts exactly LUT_BITS cycles, k = 0..7. In cycle k, cfg_s = data[7-k] and cfg_en = one-hot(addr); all other cfg_en bits are 0. MSB is shifted first so data[7] lands in Q[7] after 8 edges. in_ready=0, busy=1. After k=7, go to DONE.
  - DONE: one cycle. cfg_en=0, cfg_s=0, done=1, busy=1, in_ready=0. Then go to IDLE.
- Timing:
  - Accept edge to first cfg_en high: 1 cycle.
  - Accept to done pulse: 9 cycles.
  - Back-to-back words: one accept every 10 cycles.
- cfg_en never stays high for more or fewer than 8 consecutive cycles, except when a load is aborted by reset.
- in_valid asserted while in_ready=0 is ignored. The upstream holds the word; there is no skid buffer.
- Reset mid-SHIFT: the next cycle is IDLE with cfg_en=0 and no done. The target LUT is left partially shifted; the controller must reload it.
- Reset has priority over all transitions. Reset in the same cycle as in_valid means the word is not accepted.
- Bit counter is 3 bits and wraps from 7 to 0 on leaving SHIFT.
- done and err never assert in the same cycle.

Decomposition:
- Shared package lut_cfg_pkg:
  - LUT_BITS=8.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Function onehot(addr) returning a NUM_LUTS-wide vector.
- One natural sub-module: cfg_piso. It is an 8-bit parallel-load, MSB-first shift register with load, shift and q_msb ports. The loader FSM and counter stay in lut_cfg_loader.

Test Plan:
- Reset, then in_addr=2, in_data=8'hE8 (majority function): cfg_en=8'b0000_0100 for 8 cycles, cfg_s sequence 1,1,1,0,1,0,0,0, done 9 cycles after accept. An attached LUT model then gives Z=1 for ABC=011,101,110,111.
- Back-to-back words addr 0 data 8'h96, then addr 7 data 8'h01 with in_valid held high: the second word is accepted exactly 10 cycles after the first, cfg_en bits are never concurrently high, and LUT7 reads Q=8'h01.
- in_addr=7 with NUM_LUTS=6: err pulses one cycle, cfg_en stays 0, in_ready stays 1, no done.
- rst asserted at SHIFT cycle k=4: next cycle cfg_en=0, busy=0, in_ready=1, no done. A following load of 8'hFF completes normally.
- in_valid pulsed with a different word while busy: the word is ignored, and the cfg_s stream of the active load is unchanged.
- Exhaustive: load each of the 256 truth tables into LUT0, then sweep ABC 0..7: Z matches data bit {A,B,C}.
